// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg
// Shared types and helpers for the MMIO test monitor:
//   - mon_state_t : run-control state (RUN while logging, DONE once the verdict is latched)
//   - SIG_OK      : default expected channel-0 signature, "OK\n"
//   - addr_to_chan: maps a byte address inside the channel window to a channel index
package test_monitor_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DONE = 1'b1
  } mon_state_t;

  localparam logic [31:0] SIG_OK = 32'h004f_4b0a;

  // Channels are word spaced, so the index is the word offset from the base.
  // Up to 16 channels are supported, so four bits of index are enough.
  function automatic logic [3:0] addr_to_chan(input logic [31:0] addr, input logic [31:0] base);
    return 4'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/test_monitor_fifo.sv
// test_monitor_fifo
// Small synchronous FIFO used as the console byte queue.
// Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, din       write request and data; a push into a full FIFO is only
//                   taken when a pop happens in the same cycle
//   pop             read request; ignored while empty
//   dout            head entry (zero while empty)
//   full, empty     occupancy flags
module test_monitor_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  // The extra MSB on each pointer distinguishes full from empty when the
  // index bits are equal.
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wptr_r == rptr_r);
  assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rptr_r[AW-1:0]];

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wptr_r[AW-1:0]] <= din;
    end
  end

  // Read and write pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/test_mmio_monitor.sv
// test_mmio_monitor
// Memory-mapped test sink on the CPU data-memory write path. NUM_CHANNELS
// word-spaced channels starting at BASE_ADDR each keep a rolling byte
// signature; channel 0 also feeds a console byte FIFO. A halt pulse or the
// watchdog ends the run with a latched pass/fail verdict.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   dmem_wmask/addr/wdata            CPU store request (nonzero mask = request)
//   dmem_ready                       one-cycle store acknowledge
//   halt                             ebreak retired
//   done, pass, timeout              run finished, verdict, watchdog ended run
//   sig_flat                         channel i signature at [32i+31:32i]
//   con_valid, con_data, con_ready   console FIFO drain handshake
//   overflow                         sticky: a console byte was dropped
// Optional build macro TEST_MONITOR_TRACE_EN adds simulation trace output
// (logged writes and the final verdict); ports are identical either way.
module test_mmio_monitor
  import test_monitor_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h2000_0000,
  parameter int          NUM_CHANNELS   = 4,
  parameter int          SIG_BYTES      = 3,
  parameter logic [31:0] SIG_VALUE      = SIG_OK,
  parameter int          FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                dmem_wmask,
  input  logic [31:0]               dmem_addr,
  input  logic [31:0]               dmem_wdata,
  output logic                      dmem_ready,
  input  logic                      halt,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [32*NUM_CHANNELS-1:0] sig_flat,
  output logic                      con_valid,
  output logic [7:0]                con_data,
  input  logic                      con_ready,
  output logic                      overflow
);

  // Window end computed one bit wider so a window touching 2^32 cannot wrap.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * NUM_CHANNELS);
  localparam logic [31:0] SIG_MASK = 32'(64'h0000_0000_ffff_ffff >> (32 - 8 * SIG_BYTES));

  mon_state_t  state_r;
  mon_state_t  state_n;
  logic        pass_r;
  logic        pass_n;
  logic        timeout_r;
  logic        timeout_n;
  logic        done_r;
  logic        dmem_ready_r;
  logic        overflow_r;
  logic [31:0] cnt_r;
  logic [31:0] sig_r [NUM_CHANNELS];

  logic        hit_s;
  logic        accept_s;
  logic        log_s;
  logic [3:0]  ch_s;
  logic        expire_s;
  logic        push_s;
  logic        pop_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        unused_wdata_s;

  assign unused_wdata_s = ^dmem_wdata[31:8];

  // Decode the store against the aligned channel window
  always_comb begin
    hit_s = 1'b0;
    if ((dmem_wmask != 4'h0) &&
        ({1'b0, dmem_addr} >= {1'b0, BASE_ADDR}) &&
        ({1'b0, dmem_addr} < END_ADDR) &&
        (dmem_addr[1:0] == 2'b00)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Suppressing accept while the ack is high limits a held request to one
  // accept every two cycles.
  assign accept_s = hit_s && !dmem_ready_r;
  assign log_s    = accept_s && (state_r == RUN) && dmem_wmask[0];
  assign ch_s     = addr_to_chan(dmem_addr, BASE_ADDR);
  assign expire_s = (TIMEOUT_CYCLES != 0) && (cnt_r == 32'(TIMEOUT_CYCLES - 1));
  assign push_s   = log_s && (ch_s == 4'd0);
  assign pop_s    = !fifo_empty_s && con_ready;

  // Run-control next state and verdict
  always_comb begin
    state_n   = state_r;
    pass_n    = pass_r;
    timeout_n = timeout_r;
    case (state_r)
      RUN: begin
        if (halt) begin
          // Uses the pre-edge signature, so a same-cycle write cannot count.
          state_n   = DONE;
          pass_n    = (((sig_r[0] ^ SIG_VALUE) & SIG_MASK) == 32'h0000_0000);
          timeout_n = 1'b0;
        end else if (expire_s) begin
          state_n   = DONE;
          pass_n    = 1'b0;
          timeout_n = 1'b1;
        end else begin
          state_n   = RUN;
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: begin
        state_n   = RUN;
        pass_n    = 1'b0;
        timeout_n = 1'b0;
      end
    endcase
  end

  // Run-control state and verdict registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RUN;
      pass_r    <= 1'b0;
      timeout_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      pass_r    <= pass_n;
      timeout_r <= timeout_n;
      done_r    <= (state_n == DONE);
    end
  end

  // Saturating RUN-cycle counter for the watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 32'h0000_0000;
    end else if ((state_r == RUN) && (cnt_r != 32'hffff_ffff)) begin
      cnt_r <= cnt_r + 32'h0000_0001;
    end
  end

  // Store acknowledge pulse and sticky console overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_ready_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      dmem_ready_r <= accept_s;
      if (push_s && fifo_full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Per-channel rolling signatures, kept masked to SIG_BYTES bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        sig_r[i] <= 32'h0000_0000;
      end
    end else if (log_s) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (ch_s == 4'(i)) begin
          sig_r[i] <= ((sig_r[i] << 8) | {24'h00_0000, dmem_wdata[7:0]}) & SIG_MASK;
        end
      end
    end
  end

  test_monitor_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (dmem_wdata[7:0]),
    .pop   (pop_s),
    .dout  (con_data),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_flat
    assign sig_flat[32*g +: 32] = sig_r[g];
  end

  assign dmem_ready = dmem_ready_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign timeout    = timeout_r;
  assign overflow   = overflow_r;
  assign con_valid  = !fifo_empty_s;

`ifdef TEST_MONITOR_TRACE_EN
  string trace_label;

  // Simulation trace of logged writes and of the final verdict
  always @(posedge clk) begin
    if (!rst && log_s) begin
      $display("test_mmio_monitor: ch=%0d byte=%02h cycle=%0d", ch_s, dmem_wdata[7:0], cnt_r);
    end
    if (!rst && (state_r == RUN) && (state_n == DONE)) begin
      trace_label = "test";
      if (timeout_n) begin
        $display("timeout");
      end
      if (pass_n) begin
        $display("%s: passed", trace_label);
      end else begin
        $display("%s: failed", trace_label);
      end
    end
  end
`else
  // Trace output is compiled out; the monitor is fully synthesizable.
`endif

endmodule
